decode_stage: RTL and testbench

- RV32I instruction decode stage, directly upstream of the register file.
- Drives the register file read addresses and read enable combinationally.
- Registers the decoded control fields, immediate and PC, so they emerge in the same cycle as the register file's one-cycle registered operands.
- Supports stall (hold) and flush (bubble) from pipeline control.

---
 rtl/decode_stage.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage feeding a register file with one-cycle registered read data.
// Read addresses and read enable are driven combinationally; decoded control fields,
// immediate and PC are registered so they line up with the register file outputs.
// Optional build macro: DECODE_STAGE_RS_GATE_EN zeroes the rs1/rs2 read addresses for
// formats that do not use them.
module decode_stage #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic [DWIDTH-1:0] d_instr,
  input  logic [DWIDTH-1:0] d_pc,
  input  logic              d_valid_in,
  input  logic              d_stall,
  input  logic              d_flush,
  output logic              d_ready,
  output logic [AWIDTH-1:0] d_addr_rs_1,
  output logic [AWIDTH-1:0] d_addr_rs_2,
  output logic              d_read_reg,
  output logic [AWIDTH-1:0] d_addr_rd,
  output logic              d_we,
  output logic [DWIDTH-1:0] d_imm,
  output logic [6:0]        d_opcode,
  output logic [2:0]        d_funct3,
  output logic [6:0]        d_funct7,
  output logic [DWIDTH-1:0] d_pc_out,
  output logic              d_valid_out,
  output logic              d_illegal
);

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtIll} fmt_e;

  fmt_e              fmt;
  logic [6:0]        opcode;
  logic [31:0]       imm32;
  logic [DWIDTH-1:0] imm_dec;
  logic              we_dec;
  logic              uses_rs1;
  logic              uses_rs2;
  logic [AWIDTH-1:0] rs1_live;
  logic [AWIDTH-1:0] rs2_live;
  logic              read_reg_live;

  logic [AWIDTH-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic [DWIDTH-1:0] imm_q, imm_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [6:0]        funct7_q, funct7_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;
  logic [AWIDTH-1:0] rs1_q, rs1_d;
  logic [AWIDTH-1:0] rs2_q, rs2_d;
  logic              read_reg_q, read_reg_d;

  assign opcode = d_instr[6:0];

  // Classify the opcode into an instruction format.
  always_comb begin
    fmt = FmtIll;
    case (opcode)
      7'b0110111, 7'b0010111:                                   fmt = FmtU;
      7'b1101111:                                               fmt = FmtJ;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: fmt = FmtI;
      7'b1100011:                                               fmt = FmtB;
      7'b0100011:                                               fmt = FmtS;
      7'b0110011:                                               fmt = FmtR;
      default:                                                  fmt = FmtIll;
    endcase
  end

  // Immediate assembly, writeback enable and operand usage per format.
  always_comb begin
    imm32    = '0;
    we_dec   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (fmt)
      FmtU: begin
        imm32  = {d_instr[31:12], 12'b0};
        we_dec = 1'b1;
      end
      FmtJ: begin
        imm32  = {{11{d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20],
                  d_instr[30:21], 1'b0};
        we_dec = 1'b1;
      end
      FmtI: begin
        imm32    = {{20{d_instr[31]}}, d_instr[31:20]};
        we_dec   = 1'b1;
        uses_rs1 = 1'b1;
      end
      FmtS: begin
        imm32    = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      FmtB: begin
        imm32    = {{19{d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25],
                    d_instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      FmtR: begin
        we_dec   = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_dec       = DWIDTH'($signed(imm32));
  assign read_reg_live = d_valid_in & uses_rs1;

`ifdef DECODE_STAGE_RS_GATE_EN
  // Unused operand addresses point at x0 so they never trigger a bypass match.
  assign rs1_live = (fmt == FmtU || fmt == FmtJ) ? '0 : AWIDTH'(d_instr[19:15]);
  assign rs2_live = uses_rs2 ? AWIDTH'(d_instr[24:20]) : '0;
`else
  assign rs1_live = AWIDTH'(d_instr[19:15]);
  assign rs2_live = AWIDTH'(d_instr[24:20]);
`endif

  // Next-state: flush beats stall beats load.
  always_comb begin
    rd_d       = rd_q;
    we_d       = we_q;
    imm_d      = imm_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    illegal_d  = illegal_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    read_reg_d = read_reg_q;
    if (d_flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      // rd is kept at 0 whenever writeback is disabled.
      rd_d    = '0;
    end else if (!d_stall) begin
      we_d       = d_valid_in & we_dec;
      rd_d       = (d_valid_in & we_dec) ? AWIDTH'(d_instr[11:7]) : '0;
      imm_d      = imm_dec;
      opcode_d   = opcode;
      funct3_d   = d_instr[14:12];
      funct7_d   = d_instr[31:25];
      pc_d       = d_pc;
      valid_d    = d_valid_in;
      illegal_d  = d_valid_in & (fmt == FmtIll);
      rs1_d      = rs1_live;
      rs2_d      = rs2_live;
      read_reg_d = read_reg_live;
    end
  end

  // Pipeline registers with asynchronous active-low reset.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rd_q       <= '0;
      we_q       <= 1'b0;
      imm_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      read_reg_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      we_q       <= we_d;
      imm_q      <= imm_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      read_reg_q <= read_reg_d;
    end
  end

  // While stalled the register file keeps re-reading the held instruction's operands.
  assign d_ready     = ~d_stall;
  assign d_addr_rs_1 = d_stall ? rs1_q : rs1_live;
  assign d_addr_rs_2 = d_stall ? rs2_q : rs2_live;
  assign d_read_reg  = d_stall ? read_reg_q : read_reg_live;

  assign d_addr_rd   = rd_q;
  assign d_we        = we_q;
  assign d_imm       = imm_q;
  assign d_opcode    = opcode_q;
  assign d_funct3    = funct3_q;
  assign d_funct7    = funct7_q;
  assign d_pc_out    = pc_q;
  assign d_valid_out = valid_q;
  assign d_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, per-format decode, stall/flush, illegal opcodes.
module tb_decode_stage;

  logic        r_clk = 1'b0;
  logic        r_rst;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid_in;
  logic        d_stall;
  logic        d_flush;
  logic        d_ready;
  logic [4:0]  d_addr_rs_1;
  logic [4:0]  d_addr_rs_2;
  logic        d_read_reg;
  logic [4:0]  d_addr_rd;
  logic        d_we;
  logic [31:0] d_imm;
  logic [6:0]  d_opcode;
  logic [2:0]  d_funct3;
  logic [6:0]  d_funct7;
  logic [31:0] d_pc_out;
  logic        d_valid_out;
  logic        d_illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Addi = 32'hFFD08293;
  localparam logic [31:0] Sw   = 32'h0021A423;
  localparam logic [31:0] Beq  = 32'hFE208EE3;
  localparam logic [31:0] Add  = 32'h002081B3;
  localparam logic [31:0] Jal  = 32'h008000EF;
  localparam logic [31:0] Lui  = 32'h123452B7;
  localparam logic [31:0] Ill  = 32'h0000007F;

  decode_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .r_clk       (r_clk),
    .r_rst       (r_rst),
    .d_instr     (d_instr),
    .d_pc        (d_pc),
    .d_valid_in  (d_valid_in),
    .d_stall     (d_stall),
    .d_flush     (d_flush),
    .d_ready     (d_ready),
    .d_addr_rs_1 (d_addr_rs_1),
    .d_addr_rs_2 (d_addr_rs_2),
    .d_read_reg  (d_read_reg),
    .d_addr_rd   (d_addr_rd),
    .d_we        (d_we),
    .d_imm       (d_imm),
    .d_opcode    (d_opcode),
    .d_funct3    (d_funct3),
    .d_funct7    (d_funct7),
    .d_pc_out    (d_pc_out),
    .d_valid_out (d_valid_out),
    .d_illegal   (d_illegal)
  );

  always #5 r_clk = ~r_clk;

  // Apply inputs on the falling edge, then settle combinational outputs.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic v);
    @(negedge r_clk);
    d_instr    = instr;
    d_pc       = pc;
    d_valid_in = v;
    #1;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    r_rst = 1'b0; d_instr = '0; d_pc = '0; d_valid_in = 1'b0;
    d_stall = 1'b0; d_flush = 1'b0;
    #2;
    checks++; if (d_valid_out !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b exp 0", d_valid_out); end
    checks++; if ({d_imm, d_pc_out, d_addr_rd, d_we, d_illegal} !== 71'd0) begin errors++;
      $display("FAIL rst_fields got %h exp 0", {d_imm, d_pc_out, d_addr_rd, d_we, d_illegal});
    end
    @(negedge r_clk);
    r_rst = 1'b1;
    drive(Addi, 32'h100, 1'b1);
    tick();
    checks++; if (d_valid_out !== 1'b1 || d_pc_out !== 32'h100) begin errors++;
      $display("FAIL rst_first_load got %b/%h exp 1/100", d_valid_out, d_pc_out); end
  endtask

  task automatic test_addi();
    drive(Addi, 32'h200, 1'b1);
    checks++; if (d_addr_rs_1 !== 5'd1 || d_read_reg !== 1'b1) begin errors++;
      $display("FAIL addi_rs1 got %0d/%b exp 1/1", d_addr_rs_1, d_read_reg); end
    tick();
    checks++; if (d_imm !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL addi_imm got %h exp fffffffd", d_imm); end
    checks++; if (d_addr_rd !== 5'd5 || d_we !== 1'b1) begin errors++;
      $display("FAIL addi_rd got %0d/%b exp 5/1", d_addr_rd, d_we); end
    checks++; if (d_opcode !== 7'h13 || d_valid_out !== 1'b1 || d_illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi_ctl got %h/%b/%b exp 13/1/0", d_opcode, d_valid_out, d_illegal); end
    checks++; if (d_pc_out !== 32'h200 || d_funct7 !== 7'h7F) begin errors++;
      $display("FAIL addi_pc got %h/%h exp 200/7f", d_pc_out, d_funct7); end
  endtask

  task automatic test_sw();
    drive(Sw, 32'h204, 1'b1);
    checks++; if (d_addr_rs_1 !== 5'd3 || d_addr_rs_2 !== 5'd2) begin errors++;
      $display("FAIL sw_rs got %0d/%0d exp 3/2", d_addr_rs_1, d_addr_rs_2); end
    tick();
    checks++; if (d_imm !== 32'd8 || d_we !== 1'b0 || d_addr_rd !== 5'd0) begin errors++;
      $display("FAIL sw_out got %h/%b/%0d exp 8/0/0", d_imm, d_we, d_addr_rd); end
    checks++; if (d_funct3 !== 3'd2 || d_opcode !== 7'h23) begin errors++;
      $display("FAIL sw_f3 got %0d/%h exp 2/23", d_funct3, d_opcode); end
  endtask

  task automatic test_beq();
    drive(Beq, 32'h208, 1'b1);
    tick();
    checks++; if (d_imm !== 32'hFFFFFFFC || d_we !== 1'b0 || d_funct3 !== 3'd0) begin
      errors++;
      $display("FAIL beq_out got %h/%b/%0d exp fffffffc/0/0", d_imm, d_we, d_funct3); end
  endtask

  task automatic test_r_and_j();
    drive(Add, 32'h20C, 1'b1);
    checks++; if (d_addr_rs_1 !== 5'd1 || d_addr_rs_2 !== 5'd2 || d_read_reg !== 1'b1) begin
      errors++;
      $display("FAIL add_rs got %0d/%0d/%b exp 1/2/1", d_addr_rs_1, d_addr_rs_2, d_read_reg);
    end
    tick();
    checks++; if (d_imm !== 32'd0 || d_addr_rd !== 5'd3 || d_we !== 1'b1) begin errors++;
      $display("FAIL add_out got %h/%0d/%b exp 0/3/1", d_imm, d_addr_rd, d_we); end
    drive(Jal, 32'h210, 1'b1);
    checks++; if (d_read_reg !== 1'b0) begin errors++;
      $display("FAIL jal_rdreg got %b exp 0", d_read_reg); end
    tick();
    checks++; if (d_imm !== 32'd8 || d_addr_rd !== 5'd1 || d_we !== 1'b1) begin errors++;
      $display("FAIL jal_out got %h/%0d/%b exp 8/1/1", d_imm, d_addr_rd, d_we); end
  endtask

  task automatic test_lui();
    drive(Lui, 32'h214, 1'b1);
`ifdef DECODE_STAGE_RS_GATE_EN
    checks++; if (d_addr_rs_1 !== 5'd0 || d_addr_rs_2 !== 5'd0) begin errors++;
      $display("FAIL lui_gate got %0d/%0d exp 0/0", d_addr_rs_1, d_addr_rs_2); end
`else
    checks++; if (d_addr_rs_1 !== 5'd8 || d_addr_rs_2 !== 5'd3) begin errors++;
      $display("FAIL lui_raw got %0d/%0d exp 8/3", d_addr_rs_1, d_addr_rs_2); end
`endif
    tick();
    checks++; if (d_imm !== 32'h12345000 || d_addr_rd !== 5'd5 || d_we !== 1'b1) begin
      errors++;
      $display("FAIL lui_out got %h/%0d/%b exp 12345000/5/1", d_imm, d_addr_rd, d_we); end
  endtask

  task automatic test_illegal();
    drive(Ill, 32'h218, 1'b1);
    tick();
    checks++; if (d_illegal !== 1'b1 || d_valid_out !== 1'b1) begin errors++;
      $display("FAIL ill_flag got %b/%b exp 1/1", d_illegal, d_valid_out); end
    checks++; if (d_we !== 1'b0 || d_imm !== 32'd0 || d_addr_rd !== 5'd0) begin errors++;
      $display("FAIL ill_out got %b/%h/%0d exp 0/0/0", d_we, d_imm, d_addr_rd); end
  endtask

  task automatic test_invalid();
    drive(Addi, 32'h21C, 1'b0);
    checks++; if (d_read_reg !== 1'b0) begin errors++;
      $display("FAIL inv_rdreg got %b exp 0", d_read_reg); end
    tick();
    checks++; if (d_valid_out !== 1'b0 || d_we !== 1'b0 || d_illegal !== 1'b0) begin
      errors++;
      $display("FAIL inv_out got %b/%b/%b exp 0/0/0", d_valid_out, d_we, d_illegal); end
  endtask

  task automatic test_stall_flush();
    drive(Addi, 32'h300, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge r_clk);
      d_instr = Sw; d_pc = 32'h304; d_stall = 1'b1;
      #1;
      checks++; if (d_ready !== 1'b0 || d_addr_rs_1 !== 5'd1 || d_read_reg !== 1'b1) begin
        errors++;
        $display("FAIL stall_rd[%0d] got %b/%0d/%b exp 0/1/1", i, d_ready, d_addr_rs_1,
                 d_read_reg);
      end
      tick();
      checks++; if (d_imm !== 32'hFFFFFFFD || d_valid_out !== 1'b1 || d_pc_out !== 32'h300)
      begin
        errors++;
        $display("FAIL stall_hold[%0d] got %h/%b/%h exp fffffffd/1/300", i, d_imm,
                 d_valid_out, d_pc_out);
      end
    end
    @(negedge r_clk);
    d_flush = 1'b1;
    tick();
    checks++; if (d_valid_out !== 1'b0 || d_we !== 1'b0 || d_opcode !== 7'h13) begin
      errors++;
      $display("FAIL flush got %b/%b/%h exp 0/0/13", d_valid_out, d_we, d_opcode); end
    @(negedge r_clk);
    d_flush = 1'b0; d_stall = 1'b0;
    #1;
    checks++; if (d_ready !== 1'b1 || d_addr_rs_1 !== 5'd3) begin errors++;
      $display("FAIL release_rs got %b/%0d exp 1/3", d_ready, d_addr_rs_1); end
    tick();
    checks++; if (d_imm !== 32'd8 || d_valid_out !== 1'b1 || d_pc_out !== 32'h304) begin
      errors++;
      $display("FAIL release_load got %h/%b/%h exp 8/1/304", d_imm, d_valid_out, d_pc_out);
    end
  endtask

  task automatic test_reset_mid();
    drive(Addi, 32'h400, 1'b1);
    tick();
    @(negedge r_clk);
    d_stall = 1'b1; d_instr = Beq;
    #2;
    r_rst = 1'b0;
    #1;
    checks++; if (d_valid_out !== 1'b0 || d_imm !== 32'd0 || d_pc_out !== 32'd0) begin
      errors++;
      $display("FAIL midrst_out got %b/%h/%h exp 0/0/0", d_valid_out, d_imm, d_pc_out); end
    checks++; if (d_addr_rs_1 !== 5'd0 || d_read_reg !== 1'b0) begin errors++;
      $display("FAIL midrst_held got %0d/%b exp 0/0", d_addr_rs_1, d_read_reg); end
    @(negedge r_clk);
    r_rst = 1'b1; d_stall = 1'b0;
    drive(Beq, 32'h500, 1'b1);
    tick();
    checks++; if (d_valid_out !== 1'b1 || d_imm !== 32'hFFFFFFFC) begin errors++;
      $display("FAIL midrst_load got %b/%h exp 1/fffffffc", d_valid_out, d_imm); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sw();
    test_beq();
    test_r_and_j();
    test_lui();
    test_illegal();
    test_invalid();
    test_stall_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
